// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder: width limits and
// the values the output register takes while rst_n is low.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;
  localparam int ADDER_MAX_WIDTH     = 32;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } adder_flags_t;

  localparam logic         RST_OUT_VALID = 1'b0;
  localparam adder_flags_t RST_FLAGS     = '{cout: 1'b0, overflow: 1'b0, zero: 1'b1};

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational link of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: WIDTH full_adder cells feed an output
// register holding sum, carry-out, overflow and zero, plus a valid bit.
module four_bit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
    $error("four_bit_adder: WIDTH=%0d outside 1..%0d", WIDTH, ADDER_MAX_WIDTH);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_core;
  adder_flags_t     flags_core;
  adder_flags_t     flags_q;
  logic [WIDTH-1:0] sum_q;
  logic             valid_q;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_core[i]),
      .cout (carry[i+1])
    );
  end

  // Overflow compares carry into and out of the sign bit; at WIDTH=1 that is c[1]^c[0].
  assign flags_core.cout     = carry[WIDTH];
  assign flags_core.overflow = carry[WIDTH] ^ carry[WIDTH-1];
  assign flags_core.zero     = ~|sum_core;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      flags_q <= RST_FLAGS;
      valid_q <= RST_OUT_VALID;
    end else begin
      valid_q <= in_valid;
      // Loading only when qualified keeps undriven operands out of held results.
      if (in_valid) begin
        sum_q   <= sum_core;
        flags_q <= flags_core;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_four_bit_adder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;
  } result_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin, in_valid;
  logic [W-1:0] sum;
  logic         cout, overflow, zero, out_valid;

  logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

  int checks = 0;
  int errors = 0;
  result_t exp_q[$];

  four_bit_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Independent reference: exact integer sum for sum/cout, signed range test for overflow.
  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    result_t r;
    int unsigned total;
    int          stotal;
    total  = int'(x) + int'(y) + int'(ci);
    stotal = int'($signed(x)) + int'($signed(y)) + int'(ci);
    r.sum      = total[W-1:0];
    r.cout     = total[W];
    r.overflow = (stotal > (2**(W-1)) - 1) || (stotal < -(2**(W-1)));
    r.zero     = (total[W-1:0] == '0);
    return r;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input result_t exp_r);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    exp_q.push_back(exp_r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; a = 'x; b = 'x; cin = 1'bx;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_result: out_valid=1 with empty scoreboard at %0t", $time);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("result", {sum, cout, overflow, zero}, {e.sum, e.cout, e.overflow, e.zero});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Hand-computed directed vectors: a, b, cin -> sum, cout, overflow, zero.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    result_t      r;
  } vec_t;

  vec_t vecs[6] = '{
    '{4'b0101, 4'b1001, 1'b0, '{4'b1110, 1'b0, 1'b0, 1'b0}},
    '{4'b0110, 4'b1001, 1'b0, '{4'b1111, 1'b0, 1'b0, 1'b0}},
    '{4'b1111, 4'b0001, 1'b0, '{4'b0000, 1'b1, 1'b0, 1'b1}},
    '{4'b1111, 4'b1111, 1'b1, '{4'b1111, 1'b1, 1'b0, 1'b0}},
    '{4'b1000, 4'b1000, 1'b0, '{4'b0000, 1'b1, 1'b1, 1'b1}},
    '{4'b0111, 4'b0000, 1'b1, '{4'b1000, 1'b0, 1'b1, 1'b0}}
  };

  // {cout,sum} for index {a,b,cin}.
  logic [1:0] fa_exp[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      {fa_a, fa_b, fa_cin} = idx;
      #1;
      check($sformatf("full_adder_%0d", i), {30'd0, fa_cout, fa_sum}, {30'd0, fa_exp[i]});
    end

    #3;
    check("reset_state", {sum, cout, overflow, zero, out_valid}, {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].r);

    // Hold: last vector 0111+0000+1 must persist with out_valid low.
    idle();
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_values", {sum, cout, overflow, zero}, {4'b1000, 1'b0, 1'b1, 1'b0});
    idle();
    check("hold_values_2", {sum, cout, overflow, zero}, {4'b1000, 1'b0, 1'b1, 1'b0});

    // Asynchronous reset in the middle of a back-to-back stream.
    send(4'b0011, 4'b0100, 1'b0, model(4'b0011, 4'b0100, 1'b0));
    send(4'b1010, 4'b0011, 1'b1, model(4'b1010, 4'b0011, 1'b1));
    a = 4'b0001; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", {sum, cout, overflow, zero, out_valid}, {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("reset_held", {sum, cout, overflow, zero, out_valid}, {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});
    in_valid = 1'b0;
    rst_n = 1'b1;

    // First accepted input after release appears exactly one cycle later.
    send(4'b0010, 4'b0011, 1'b1, model(4'b0010, 4'b0011, 1'b1));
    check("latency_after_reset", {sum, out_valid}, {4'b0110, 1'b1});
    idle();

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom_range(0, 2**W - 1));
      rb = W'($urandom_range(0, 2**W - 1));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc));
    end

    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
